// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_t;

  localparam int DATA_W       = 8;
  localparam int CLKS_PER_BIT = 13021;   // 125 MHz / 9600 baud

  // Ten bit times is 130210 clocks; leave margin above that.
  localparam int DEF_DONE_TIMEOUT = 200000;
  // Roughly one hundred bit times of silence from a locked requester.
  localparam int DEF_HOLD_TIMEOUT = 1302100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin one-hot picker: first set request at or above i_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; result follows the inputs.
// Ports: i_req (request vector), i_ptr (highest-priority index),
//        o_onehot / o_idx (winner), o_any (at least one request).
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among NUM_REQ requesters, round-robin, packet-locked.
// Latency: transfer at cycle n -> tx_start at n+1; next transfer possible the cycle after tx_done.
// Backpressure: req_ready only in IDLE (winner) or HOLD (owner); silent while a byte is in flight.
// Ports: clk/rst (sync, active-low); i_req_valid/i_req_data/i_req_last/o_req_ready per requester;
//        o_grant one-hot owner; o_tx_start/o_tx_data/i_tx_done to the transmitter;
//        o_busy (not IDLE); o_err_pulse/o_err_id report done or hold timeouts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_tx_start,
  output logic [DATA_W-1:0]          o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_err_pulse,
  output logic [$clog2(NUM_REQ)-1:0] o_err_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(DONE_TIMEOUT, HOLD_TIMEOUT) + 1);

  arb_state_t r_state, w_next;

  logic [IDX_W-1:0]  r_owner, r_rr_ptr, r_err_id;
  logic [NUM_REQ-1:0] r_grant;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_last, r_err_pulse;
  logic [CNT_W-1:0]  r_cnt;

  logic [NUM_REQ-1:0]             w_pick_onehot;
  logic [IDX_W-1:0]               w_pick_idx, w_sel;
  logic                           w_pick_any;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_bytes;
  logic [NUM_REQ-1:0]             w_ready;
  logic w_accept, w_release, w_timeout, w_cnt_clr, w_tx_start;

  assign w_bytes = i_req_data;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // In HOLD the locked owner is the only candidate, so the picker is bypassed.
  assign w_sel = (r_state == IDLE) ? w_pick_idx : r_owner;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ready    = '0;
    w_accept   = 1'b0;
    w_release  = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_tx_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_ready  = w_pick_onehot;
          w_accept = 1'b1;
          w_next   = SEND;
        end
      end
      SEND: begin
        w_tx_start = 1'b1;
        w_cnt_clr  = 1'b1;
        w_next     = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done is checked first so a coincident timeout is not reported.
        if (i_tx_done) begin
          if (r_last) begin
            w_release = 1'b1;
            w_next    = IDLE;
          end else begin
            w_cnt_clr = 1'b1;
            w_next    = HOLD;
          end
        end else if (r_cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      HOLD: begin
        if (i_req_valid[r_owner]) begin
          w_ready[r_owner] = 1'b1;
          w_accept         = 1'b1;
          w_next           = SEND;
        end else if (r_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_id    <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_tx_data <= w_bytes[w_sel];
        r_last    <= i_req_last[w_sel];
        r_owner   <= w_sel;
      end
      if (w_accept && (r_state == IDLE)) r_grant <= w_pick_onehot;
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
      end
      // Pulse lands together with the return to IDLE, err_id already valid.
      r_err_pulse <= w_timeout;
      if (w_timeout) r_err_id <= r_owner;
      if (w_cnt_clr)                                      r_cnt <= '0;
      else if ((r_state == WAIT_DONE) || (r_state == HOLD)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_req_ready = w_ready;
  assign o_grant     = r_grant;
  assign o_tx_start  = w_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_busy      = (r_state != IDLE);
  assign o_err_pulse = r_err_pulse;
  assign o_err_id    = r_err_id;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one serial transmitter (8-bit byte interface: start pulse in, done pulse out) between NUM_REQ requesters using round-robin arbitration with packet locking.
- Each requester presents bytes on a valid/ready interface with a last flag.
- A granted requester keeps the transmitter until its last byte completes, so multi-byte messages are never interleaved.
- Sits between on-chip message sources (status reporter, debug console, etc.) and the transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DONE_TIMEOUT, 200000, max clk cycles waited for tx_done after tx_start (>= 10 bit times at 125 MHz/9600 baud = 130210)
HOLD_TIMEOUT, 1302100, max clk cycles a locked requester may leave req_valid low mid-packet before the lock is dropped

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is final byte of packet
req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i]
grant  out  NUM_REQ  one-hot owner of the transmitter, 0 when free
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmitter, stable from tx_start until tx_done
tx_done  in  1  one-cycle completion pulse from transmitter
busy  out  1  high in any state other than IDLE
err_pulse  out  1  one-cycle pulse on any timeout
err_id  out  $clog2(NUM_REQ)  requester index owning the lock at the last timeout

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. tx_start=0, tx_data=0, grant=0, busy=0, err_pulse=0, err_id=0. rr_ptr=0, so requester 0 has top priority. Counters=0. Applies mid-byte or mid-packet; any partially sent packet is abandoned.
- States: IDLE, SEND, WAIT_DONE, HOLD.
- IDLE: winner = first i with req_valid[i], searching from rr_ptr upward and wrapping. req_ready[winner]=1 combinationally, all others 0. On transfer:
  - latch byte into tx_data, latch last into last_q, latch index into owner
  - grant<=onehot(owner), go to SEND
  - no valid -> remain in IDLE, grant=0.
- SEND: tx_start=1 for exactly one cycle, then WAIT_DONE. Clear the timeout counter.
- WAIT_DONE: count cycles.
  - tx_done=1 and last_q=1 -> rr_ptr<=owner+1 (mod NUM_REQ), grant<=0, go to IDLE.
  - tx_done=1 and last_q=0 -> go to HOLD.
  - counter reaches DONE_TIMEOUT-1 without tx_done -> err_pulse, err_id<=owner, release as for last byte, go to IDLE.
  - tx_done and timeout in the same cycle -> tx_done wins, no error.
- HOLD: req_ready[owner]=1 only when req_valid[owner]; others 0. Grant is held.
  - transfer -> latch byte and last, go to SEND.
  - HOLD_TIMEOUT cycles with no valid -> err_pulse, err_id<=owner, release, go to IDLE.
- Minimum byte-to-byte spacing: transfer at cycle n; tx_start at n+1; after tx_done at cycle m, the next transfer can occur at m+1 (HOLD) or m+1 (IDLE).
- tx_done while in IDLE, SEND or HOLD is ignored.
- tx_start is never asserted outside SEND.
- req_ready is never asserted while in SEND or WAIT_DONE.
- A requester whose req_valid drops before its transfer loses arbitration with no side effects.

Decomposition:
- Package uart_pkg: arb_state_t enum {IDLE, SEND, WAIT_DONE, HOLD}, DATA_W=8, CLKS_PER_BIT=13021, default timeout constants.
- Sub-module uart_rr_pick: combinational round-robin one-hot picker (inputs req vector and rr_ptr; outputs one-hot winner and index, plus any_valid). Parameterised by NUM_REQ.

Test Plan:
- Single requester, req 1 sends 0xA5 with last=1 -> tx_start one cycle after transfer with tx_data=0xA5. grant=0010 until tx_done, then grant=0 and busy=0 next cycle.
- Round-robin, all four requesters continuously valid with single-byte packets, starting from reset -> service order 0,1,2,3,0; no requester serviced twice in a row.
- Packet lock, req 2 sends 3 bytes (0x11, 0x22, 0x33 last) while req 0 stays valid -> three tx_starts for req 2 back to back, then req 0 is granted.
- Done timeout, model never pulses tx_done -> err_pulse after exactly DONE_TIMEOUT cycles, err_id=owner, state returns to IDLE, next requester is served.
- Hold timeout, req 3 sends a non-last byte then drops valid -> err_pulse HOLD_TIMEOUT cycles after entering HOLD, err_id=3, lock released.
- Reset during WAIT_DONE -> all outputs at reset values the next cycle; first grant after reset goes to the lowest valid index.
